// File: rtl/posit_lod_arbiter_pkg.sv
// Shared sizing helpers for the posit leading-one-detect arbiter slice.
package posit_lod_pkg;

    function automatic int unsigned w_of(input int unsigned n, input int unsigned es);
        return n - es + 3;
    endfunction

    function automatic int unsigned cw_of(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // A single lane still needs a 1-bit tag so the response struct stays well formed.
    function automatic int unsigned idw_of(input int unsigned nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/posit_lod_arbiter_if.sv
// Request/response bundle between the adder lanes and the shared LOD datapath.
interface posit_lod_arbiter_if
    import posit_lod_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = w_of(8, 4),
    parameter int unsigned CW   = cw_of(W),
    parameter int unsigned IDW  = idw_of(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [CW-1:0]     rsp_count;
    logic              rsp_zero;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_zero
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count, rsp_zero
    );
endinterface

// File: rtl/posit_lod_arbiter_lod_count.sv
// Combinational MSB-first leading-zero count with an all-zero flag.
module lod_count #(
    parameter int unsigned W  = 7,
    parameter int unsigned CW = 3
) (
    input  logic [W-1:0]  word_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);
    // Scan upward so the most significant set bit is the last one to win.
    always_comb begin
        count_o = CW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (word_i[i]) begin
                count_o = CW'(W - 1 - i);
            end
        end
    end

    assign zero_o = ~|word_i;
endmodule

// File: rtl/posit_lod_arbiter.sv
// Round-robin shared leading-one detector: S1 holds the granted word, S2 the tagged result.
module posit_lod_arbiter
    import posit_lod_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned es   = 4,
    parameter int unsigned NREQ = 4
) (
    input logic               clk,
    input logic               rst_n,
    posit_lod_arbiter_if.slave bus
);
    localparam int unsigned W   = w_of(N, es);
    localparam int unsigned CW  = cw_of(W);
    localparam int unsigned IDW = idw_of(NREQ);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  count;
        logic           zero;
    } lod_rsp_t;

    logic             s1_valid_q;
    logic [W-1:0]     s1_word_q;
    logic [IDW-1:0]   s1_id_q;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q;
    lod_rsp_t         rsp_q, rsp_d;

    logic             s2_adv, s1_adv, any_req, accept, found;
    logic [IDW-1:0]   winner, idx;
    logic [IDW:0]     sum;
    logic [W-1:0]     data_sel;
    logic [NREQ-1:0]  ready;
    logic [CW-1:0]    lc_count;
    logic             lc_zero;

    assign s2_adv  = !rsp_valid_q || bus.rsp_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign any_req = |bus.req_valid;
    assign accept  = any_req && s1_adv;

    // Search starts at the pointer; the wide sum makes wrap explicit for any NREQ.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && bus.req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == winner) begin
                data_sel = bus.req_data[k*W +: W];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (accept && rst_n) begin
            ready[winner] = 1'b1;
        end
    end

    assign ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

    lod_count #(.W(W), .CW(CW)) u_lod_count (
        .word_i  (s1_word_q),
        .count_o (lc_count),
        .zero_o  (lc_zero)
    );

    always_comb begin
        rsp_d       = rsp_q;
        rsp_d.id    = s1_id_q;
        rsp_d.count = lc_count;
        rsp_d.zero  = lc_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_id_q     <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= any_req;
                if (any_req) begin
                    s1_word_q <= data_sel;
                    s1_id_q   <= winner;
                    ptr_q     <= ptr_d;
                end
            end
            if (s2_adv) begin
                rsp_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rsp_q <= rsp_d;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.rsp_count = rsp_q.count;
    assign bus.rsp_zero  = rsp_q.zero;
endmodule

// File: tb/tb_posit_lod_arbiter.sv
// Directed bench for posit_lod_arbiter with N=8, es=4 (W=7, CW=3) and four lanes.
module tb_posit_lod_arbiter;
    import posit_lod_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 7;
    localparam int unsigned CW   = 3;
    localparam int unsigned IDW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    posit_lod_arbiter_if #(.NREQ(NREQ), .W(W), .CW(CW), .IDW(IDW)) bus ();

    posit_lod_arbiter #(.N(8), .es(4), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int unsigned lane;
        logic [6:0]  word;
        int unsigned cnt;
        logic        zero;
    } vec_t;

    typedef struct {
        int unsigned id;
        int unsigned cnt;
        logic        zero;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sb[$];
    logic [6:0]  wtab[8];
    int unsigned ctab[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_single(input string nm, input int unsigned lane, input logic [6:0] word,
                              input int unsigned ec, input logic ez);
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.req_valid[lane] = 1'b1;
        bus.req_data[lane*W +: W] = word;
        @(negedge clk);
        check({nm, " req_ready"}, 32'(bus.req_ready), 32'(1 << lane));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check({nm, " early rsp_valid"}, 32'(bus.rsp_valid), 0);
        @(negedge clk);
        check({nm, " rsp_valid"}, 32'(bus.rsp_valid), 1);
        check({nm, " rsp_id"}, 32'(bus.rsp_id), lane);
        check({nm, " rsp_count"}, 32'(bus.rsp_count), ec);
        check({nm, " rsp_zero"}, 32'(bus.rsp_zero), 32'(ez));
    endtask

    initial begin
        logic [NREQ-1:0] acc;
        int unsigned     wi[NREQ];
        logic            hold;
        logic [IDW-1:0]  h_id;
        logic [CW-1:0]   h_cnt;
        logic            h_zero;
        exp_t            e;

        vecs[0] = '{lane: 2, word: 7'b0010110, cnt: 2, zero: 1'b0};
        vecs[1] = '{lane: 0, word: 7'b0000000, cnt: 7, zero: 1'b1};
        vecs[2] = '{lane: 1, word: 7'b1000000, cnt: 0, zero: 1'b0};
        vecs[3] = '{lane: 3, word: 7'b0000001, cnt: 6, zero: 1'b0};
        vecs[4] = '{lane: 0, word: 7'b0111111, cnt: 1, zero: 1'b0};
        vecs[5] = '{lane: 1, word: 7'b0000100, cnt: 4, zero: 1'b0};
        vecs[6] = '{lane: 2, word: 7'b0001000, cnt: 3, zero: 1'b0};
        vecs[7] = '{lane: 3, word: 7'b0000011, cnt: 5, zero: 1'b0};

        wtab[0] = 7'b1000000; ctab[0] = 0;
        wtab[1] = 7'b0100000; ctab[1] = 1;
        wtab[2] = 7'b0010000; ctab[2] = 2;
        wtab[3] = 7'b0001011; ctab[3] = 3;
        wtab[4] = 7'b0000111; ctab[4] = 4;
        wtab[5] = 7'b0000010; ctab[5] = 5;
        wtab[6] = 7'b0000001; ctab[6] = 6;
        wtab[7] = 7'b0000000; ctab[7] = 7;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // Reset held from time zero; probe mid-cycle with every lane requesting.
        #12;
        bus.req_valid = '1;
        #1;
        check("reset req_ready", 32'(bus.req_ready), 0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 0);
        bus.req_valid = '0;
        @(posedge clk); #3;
        rst_n = 1'b1;

        @(posedge clk); #1;
        bus.req_valid = '1;
        @(negedge clk);
        check("reset pointer", 32'(bus.req_ready), 32'h1);
        #1;
        bus.req_valid = '0;

        for (int i = 0; i < 8; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].lane, vecs[i].word, vecs[i].cnt, vecs[i].zero);
        end

        // Fairness: all lanes requesting continuously, lane L word has L leading zeros.
        @(posedge clk); #1;
        for (int l = 0; l < int'(NREQ); l++) begin
            bus.req_data[l*W +: W] = 7'b1000000 >> l;
        end
        bus.req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr ready %0d", i), 32'(bus.req_ready), 32'(1 << (i % 4)));
            if (i >= 2) begin
                check($sformatf("rr rsp_valid %0d", i), 32'(bus.rsp_valid), 1);
                check($sformatf("rr rsp_id %0d", i), 32'(bus.rsp_id), (i - 2) % 4);
                check($sformatf("rr rsp_count %0d", i), 32'(bus.rsp_count), (i - 2) % 4);
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        check("rr drained", 32'(bus.rsp_valid), 0);

        // Backpressure stream with a per-acceptance scoreboard.
        @(posedge clk); #1;
        for (int l = 0; l < int'(NREQ); l++) begin
            wi[l] = l;
            bus.req_data[l*W +: W] = wtab[wi[l] % 8];
        end
        bus.req_valid = '1;
        hold = 1'b0;
        h_id = '0; h_cnt = '0; h_zero = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (hold) begin
                check($sformatf("bp hold valid %0d", cyc), 32'(bus.rsp_valid), 1);
                check($sformatf("bp hold id %0d", cyc), 32'(bus.rsp_id), 32'(h_id));
                check($sformatf("bp hold count %0d", cyc), 32'(bus.rsp_count), 32'(h_cnt));
                check($sformatf("bp hold zero %0d", cyc), 32'(bus.rsp_zero), 32'(h_zero));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("bp duplicate", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("bp id %0d", cyc), 32'(bus.rsp_id), e.id);
                    check($sformatf("bp count %0d", cyc), 32'(bus.rsp_count), e.cnt);
                    check($sformatf("bp zero %0d", cyc), 32'(bus.rsp_zero), 32'(e.zero));
                end
            end
            hold   = bus.rsp_valid && !bus.rsp_ready;
            h_id   = bus.rsp_id;
            h_cnt  = bus.rsp_count;
            h_zero = bus.rsp_zero;
            if (cyc >= 6 && cyc <= 8) begin
                check($sformatf("bp stall ready %0d", cyc), 32'(bus.req_ready), 0);
            end
            acc = bus.req_ready;
            for (int l = 0; l < int'(NREQ); l++) begin
                if (acc[l]) begin
                    e.id   = l;
                    e.cnt  = ctab[wi[l] % 8];
                    e.zero = (wi[l] % 8) == 7;
                    sb.push_back(e);
                end
            end
            @(posedge clk); #1;
            for (int l = 0; l < int'(NREQ); l++) begin
                if (acc[l]) begin
                    wi[l]++;
                    bus.req_data[l*W +: W] = wtab[wi[l] % 8];
                end
            end
            bus.rsp_ready = !((cyc + 1) >= 6 && (cyc + 1) <= 8);
            if (cyc == 19) bus.req_valid = '0;
        end
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                e = sb.pop_front();
                check($sformatf("bp drain id %0d", c), 32'(bus.rsp_id), e.id);
                check($sformatf("bp drain count %0d", c), 32'(bus.rsp_count), e.cnt);
                check($sformatf("bp drain zero %0d", c), 32'(bus.rsp_zero), 32'(e.zero));
            end
        end
        check("bp results outstanding", sb.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check("bp no extra result", 32'(bus.rsp_valid), 0);

        // Reset with two words in flight and the consumer stalled.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data[0*W +: W] = 7'b0000001;
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        bus.req_data[1*W +: W] = 7'b0000011;
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        check("midrst in flight", 32'(bus.rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        bus.req_valid = '1;
        #1;
        check("midrst rsp_valid", 32'(bus.rsp_valid), 0);
        check("midrst req_ready", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst no rsp %0d", i), 32'(bus.rsp_valid), 0);
        end
        @(posedge clk); #1;
        bus.req_valid = '1;
        @(negedge clk);
        check("midrst pointer", 32'(bus.req_ready), 32'h1);
        #1;
        bus.req_valid = '0;
        run_single("post reset", 3, 7'b0000100, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
